bsg_decoder: RTL and testbench

BSG_DECODER -- requirements
Module: bsg_decoder

---
 rtl/bsg_decoder_if.sv | 25 ++
 rtl/bsg_decoder.sv | 183 ++++++++++++++++++
 tb/tb_bsg_decoder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_decoder_if.sv
// Decoder link bundle: Manchester chip input side plus the held-frame output
// handshake and the error pulses. The decoder uses 'master', the environment 'slave'.
interface bsg_decoder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_chip_valid;
  logic                  rx_chip;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  code_err;
  logic                  overflow;
  logic                  parity_err;

  modport master (
    input  rx_chip_valid, rx_chip, out_ready,
    output out_valid, addr_out, data_out, code_err, overflow, parity_err
  );

  modport slave (
    output rx_chip_valid, rx_chip, out_ready,
    input  out_valid, addr_out, data_out, code_err, overflow, parity_err
  );
endinterface

// File: rtl/bsg_decoder.sv
// Manchester frame decoder: hunts for SFD 0xD5, then collects address and data fields.
// Optional even-parity bit after the data field is compiled in with `define BSG_DEC_PARITY_EN.
module bsg_decoder #(
  parameter int DATA_WIDTH = 8
) (
  input logic         SYS_CLK,
  input logic         rst,
  bsg_decoder_if.master bus
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0] SFD = 8'hD5;

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
`ifdef BSG_DEC_PARITY_EN
  localparam logic [1:0] PARITY = 2'd3;
`endif

  logic [1:0]            state;
  logic                  phase;
  logic                  first_chip;
  // Only the 7 most recent bits need storing; the 8th comes from the incoming pair.
  logic [6:0]            sfd_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] addr_sh;
`ifdef BSG_DEC_PARITY_EN
  logic [DATA_WIDTH-1:0] data_sh;
`else
  logic [DATA_WIDTH-2:0] data_sh;
`endif
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  code_err_r;
  logic                  overflow_r;

  logic                  violation;
  logic                  good_bit;
  logic                  field_last;
  logic                  can_load;
  logic                  frame_done;
  logic [7:0]            sfd_next;
  logic [DATA_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [DATA_WIDTH-1:0] frame_data;

  always_comb begin
    violation  = bus.rx_chip_valid & phase & (first_chip == bus.rx_chip);
    good_bit   = bus.rx_chip_valid & phase & (first_chip != bus.rx_chip);
    field_last = (bit_cnt == LAST_BIT);
    can_load   = ~out_valid_r | bus.out_ready;
    sfd_next   = {sfd_reg, bus.rx_chip};
    addr_next  = {addr_sh[DATA_WIDTH-2:0], bus.rx_chip};
`ifdef BSG_DEC_PARITY_EN
    data_next  = {data_sh[DATA_WIDTH-2:0], bus.rx_chip};
    frame_data = data_sh;
    frame_done = good_bit & (state == PARITY) & ~(^{addr_sh, data_sh, bus.rx_chip});
`else
    data_next  = {data_sh, bus.rx_chip};
    frame_data = data_next;
    frame_done = good_bit & (state == DATA) & field_last;
`endif
  end

  // Output holding register: a new frame may replace the held one only when it is being consumed.
  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      overflow_r  <= 1'b0;
    end else begin
      overflow_r <= frame_done & ~can_load;
      if (frame_done && can_load) begin
        out_valid_r <= 1'b1;
        addr_r      <= addr_sh;
        data_r      <= frame_data;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef BSG_DEC_PARITY_EN
  logic parity_err_r;

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= good_bit & (state == PARITY) & (^{addr_sh, data_sh, bus.rx_chip});
    end
  end

  assign bus.parity_err = parity_err_r;
`else
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state      <= HUNT;
      phase      <= 1'b0;
      first_chip <= 1'b0;
      sfd_reg    <= '0;
      bit_cnt    <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      code_err_r <= 1'b0;
    end else begin
      code_err_r <= 1'b0;
      if (bus.rx_chip_valid) begin
        if (!phase) begin
          first_chip <= bus.rx_chip;
          phase      <= 1'b1;
        end else if (violation) begin
          // While hunting, slip one chip so the pairing can realign.
          if (state == HUNT) begin
            first_chip <= bus.rx_chip;
          end else begin
            code_err_r <= 1'b1;
            state      <= HUNT;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            sfd_reg    <= '0;
          end
        end else begin
          phase <= 1'b0;
          case (state)
            HUNT: begin
              if (sfd_next == SFD) begin
                state   <= ADDR;
                sfd_reg <= '0;
                bit_cnt <= '0;
              end else begin
                sfd_reg <= sfd_next[6:0];
              end
            end
            ADDR: begin
              addr_sh <= addr_next;
              if (field_last) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            DATA: begin
`ifdef BSG_DEC_PARITY_EN
              data_sh <= data_next;
`else
              data_sh <= data_next[DATA_WIDTH-2:0];
`endif
              if (field_last) begin
                bit_cnt <= '0;
`ifdef BSG_DEC_PARITY_EN
                state   <= PARITY;
`else
                state   <= HUNT;
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= HUNT;
            end
          endcase
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.addr_out  = addr_r;
  assign bus.data_out  = data_r;
  assign bus.code_err  = code_err_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_bsg_decoder.sv
// Self-checking bench for bsg_decoder: directed scenarios plus randomized frames,
// compared every cycle against a bit-queue reference model.
module tb_bsg_decoder;

  localparam int W = 8;
`ifdef BSG_DEC_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int FRAME_BITS = 2 * W + int'(PARITY_ON);

  typedef bit chipq_t[$];

  logic SYS_CLK = 1'b0;
  logic rst;

  bsg_decoder_if #(.DATA_WIDTH(W)) bus ();

  bsg_decoder #(.DATA_WIDTH(W)) dut (
    .SYS_CLK(SYS_CLK),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  bit ready_q    = 1'b1;
  bit rand_ready = 1'b0;

  // Reference model: hunt flag, SFD history as an integer, received field bits as a queue.
  bit           m_hunting = 1'b1;
  bit           m_have    = 1'b0;
  bit           m_first   = 1'b0;
  int           m_sfd     = 0;
  bit           m_bits[$];
  bit           e_valid   = 1'b0;
  logic [W-1:0] e_addr    = '0;
  logic [W-1:0] e_data    = '0;
  bit           e_code    = 1'b0;
  bit           e_ovf     = 1'b0;
  bit           e_par     = 1'b0;

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(bit r, bit v, bit c, bit rdy);
    bit old_valid;
    bit loaded;
    int ai;
    int di;
    int ones;
    old_valid = e_valid;
    loaded    = 1'b0;
    e_code    = 1'b0;
    e_ovf     = 1'b0;
    e_par     = 1'b0;
    if (r) begin
      m_hunting = 1'b1;
      m_have    = 1'b0;
      m_sfd     = 0;
      m_bits.delete();
      e_valid   = 1'b0;
      e_addr    = '0;
      e_data    = '0;
      return;
    end
    if (v) begin
      if (!m_have) begin
        m_first = c;
        m_have  = 1'b1;
      end else if (m_first == c) begin
        if (m_hunting) begin
          m_first = c;
        end else begin
          e_code    = 1'b1;
          m_hunting = 1'b1;
          m_have    = 1'b0;
          m_sfd     = 0;
          m_bits.delete();
        end
      end else begin
        m_have = 1'b0;
        if (m_hunting) begin
          m_sfd = (m_sfd * 2 + int'(c)) % 256;
          if (m_sfd == 'hD5) begin
            m_hunting = 1'b0;
            m_sfd     = 0;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(c);
          if (m_bits.size() == FRAME_BITS) begin
            ai   = 0;
            di   = 0;
            ones = 0;
            for (int i = 0; i < W; i++) begin
              ai = ai * 2 + int'(m_bits[i]);
              di = di * 2 + int'(m_bits[W + i]);
            end
            for (int i = 0; i < FRAME_BITS; i++) ones += int'(m_bits[i]);
            m_bits.delete();
            m_hunting = 1'b1;
            if (PARITY_ON && (ones % 2 != 0)) begin
              e_par = 1'b1;
            end else if (!old_valid || rdy) begin
              e_valid = 1'b1;
              e_addr  = W'(ai);
              e_data  = W'(di);
              loaded  = 1'b1;
            end else begin
              e_ovf = 1'b1;
            end
          end
        end
      end
    end
    if (old_valid && rdy && !loaded) e_valid = 1'b0;
  endtask

  task automatic checkOutput();
    check("out_valid",  W'(bus.out_valid),  W'(e_valid));
    check("addr_out",   bus.addr_out,       e_addr);
    check("data_out",   bus.data_out,       e_data);
    check("code_err",   W'(bus.code_err),   W'(e_code));
    check("overflow",   W'(bus.overflow),   W'(e_ovf));
    check("parity_err", W'(bus.parity_err), W'(e_par));
  endtask

  task automatic applyStimulus(bit r, bit v, bit c);
    if (rand_ready) ready_q = 1'($urandom_range(0, 1));
    rst               = r;
    bus.rx_chip_valid = v;
    bus.rx_chip       = c;
    bus.out_ready     = ready_q;
    @(posedge SYS_CLK);
    model_step(r, v, c, ready_q);
    #1;
    checkOutput();
  endtask

  function automatic bit goodPar(logic [W-1:0] a, logic [W-1:0] d);
    return (^a) ^ (^d);
  endfunction

  // Preamble of eight 0 bits, SFD sent MSB first, then address, data and optional parity.
  function automatic chipq_t buildChips(logic [W-1:0] a, logic [W-1:0] d, bit par);
    chipq_t     q;
    bit         b[$];
    logic [7:0] sfd;
    sfd = 8'hD5;
    for (int i = 0; i < 8; i++) b.push_back(1'b0);
    for (int i = 7; i >= 0; i--) b.push_back(sfd[i]);
    for (int i = W - 1; i >= 0; i--) b.push_back(a[i]);
    for (int i = W - 1; i >= 0; i--) b.push_back(d[i]);
    if (PARITY_ON) b.push_back(par);
    foreach (b[i]) begin
      if (b[i]) begin
        q.push_back(1'b0);
        q.push_back(1'b1);
      end else begin
        q.push_back(1'b1);
        q.push_back(1'b0);
      end
    end
    return q;
  endfunction

  task automatic sendChips(chipq_t q, int from, int upto, bit gaps);
    for (int i = from; i < upto; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 1'($urandom));
      end
      applyStimulus(1'b0, 1'b1, q[i]);
    end
  endtask

  task automatic sendFrame(logic [W-1:0] a, logic [W-1:0] d, bit gaps);
    chipq_t q;
    q = buildChips(a, d, goodPar(a, d));
    sendChips(q, 0, q.size(), gaps);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    chipq_t       q;
    logic [W-1:0] ra;
    logic [W-1:0] rd;
    int           idx;

    rst               = 1'b1;
    bus.rx_chip_valid = 1'b0;
    bus.rx_chip       = 1'b0;
    bus.out_ready     = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    check("reset_valid", W'(bus.out_valid), '0);
    check("reset_addr",  bus.addr_out,      '0);
    idle(2);

    // Nominal frame, consumer always ready
    ready_q = 1'b1;
    sendFrame(8'h3C, 8'hA5, 1'b0);
    check("nominal_valid", W'(bus.out_valid), W'(1));
    check("nominal_addr",  bus.addr_out,      8'h3C);
    check("nominal_data",  bus.data_out,      8'hA5);
    idle(3);
    check("nominal_clear", W'(bus.out_valid), '0);

    // Leading stray chip forces a slip while hunting
    q = buildChips(8'h3C, 8'hA5, goodPar(8'h3C, 8'hA5));
    q.push_front(1'b1);
    sendChips(q, 0, q.size(), 1'b0);
    check("misalign_addr", bus.addr_out, 8'h3C);
    check("misalign_data", bus.data_out, 8'hA5);
    idle(3);

    // "11" pair at data bit 3
    q   = buildChips(8'h12, 8'h34, goodPar(8'h12, 8'h34));
    idx = 2 * (16 + W + 3);
    q[idx]     = 1'b1;
    q[idx + 1] = 1'b1;
    sendChips(q, 0, idx + 2, 1'b0);
    check("viol_code", W'(bus.code_err), W'(1));
    sendChips(q, idx + 2, q.size(), 1'b0);
    check("viol_novalid", W'(bus.out_valid), '0);
    idle(2);
    sendFrame(8'h56, 8'h78, 1'b0);
    check("viol_recover_addr", bus.addr_out, 8'h56);
    idle(3);

    // Back-pressure: second frame overflows
    ready_q = 1'b0;
    sendFrame(8'h11, 8'h22, 1'b0);
    check("bp_first_valid", W'(bus.out_valid), W'(1));
    sendFrame(8'h33, 8'h44, 1'b0);
    check("bp_overflow", W'(bus.overflow), W'(1));
    check("bp_hold_addr", bus.addr_out, 8'h11);
    check("bp_hold_data", bus.data_out, 8'h22);
    ready_q = 1'b1;
    idle(1);
    check("bp_release", W'(bus.out_valid), '0);
    idle(2);

    // Reset during the address field
    q = buildChips(8'h9A, 8'hBC, goodPar(8'h9A, 8'hBC));
    sendChips(q, 0, 2 * (16 + 3), 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("midrst_addr", bus.addr_out, '0);
    check("midrst_data", bus.data_out, '0);
    sendFrame(8'hC3, 8'h5A, 1'b0);
    check("midrst_recover", bus.data_out, 8'h5A);
    idle(3);

`ifdef BSG_DEC_PARITY_EN
    q = buildChips(8'h01, 8'h00, 1'b0);
    sendChips(q, 0, q.size(), 1'b0);
    check("parity_bad", W'(bus.parity_err), W'(1));
    check("parity_novalid", W'(bus.out_valid), '0);
    idle(2);
    q = buildChips(8'h01, 8'h00, 1'b1);
    sendChips(q, 0, q.size(), 1'b0);
    check("parity_good_addr", bus.addr_out, 8'h01);
    idle(3);
`endif

    // Random frames with idle gaps, random back-pressure and occasional corrupted chips
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rd = W'($urandom);
      q  = buildChips(ra, rd, ($urandom_range(0, 5) == 0) ? ~goodPar(ra, rd) : goodPar(ra, rd));
      if ($urandom_range(0, 4) == 0) begin
        idx    = $urandom_range(0, q.size() - 1);
        q[idx] = ~q[idx];
      end
      if ($urandom_range(0, 3) == 0) q.push_front(1'($urandom));
      sendChips(q, 0, q.size(), 1'b1);
      idle($urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ready_q    = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
